// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM encoding, word geometry
// and the address legality check used at execution time.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 4;

    // A request is illegal when it is not word aligned or indexes past the array.
    function automatic logic is_bad_addr(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// Single-port word array with byte-enabled synchronous write and registered read.
// Contents and the read register are deliberately left unreset.
module dmem_word_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the MEM-stage data-memory interface: one request at a time, a
// programmable wait-state latency, and a held response over a valid/ready handshake.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output state_t      dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // initiator holds its payload stable while valid && !ready, and the responder
    // holds rsp_valid/rsp_rdata/rsp_err stable until rsp_ready is seen.

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAT_M1 = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 0..15");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("dmem_responder: DEPTH_WORDS must be a power of 2");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               cap_we;
    logic [31:0]        cap_addr;
    logic [31:0]        cap_wdata;
    logic [3:0]         cap_be;
    logic               rsp_err_q;
    logic               rsp_load_q;
    logic               bad_addr;
    logic               ram_en;
    logic [31:0]        ram_rdata;

    assign bad_addr = is_bad_addr(cap_addr, DEPTH_WORDS);
    assign ram_en   = (state_q == ST_EXEC) && !bad_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_valid) state_d = (LATENCY > 0) ? ST_WAIT : ST_EXEC;
            ST_WAIT: if (cnt_q == '0) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
        rsp_err   = rsp_err_q;
        // Load data lives in the RAM read register; it is exposed only for a good load.
        rsp_rdata = rsp_load_q ? ram_rdata : '0;
        dbg_state = state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_be     <= '0;
            cnt_q      <= '0;
            rsp_err_q  <= 1'b0;
            rsp_load_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && req_valid) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_be    <= req_be;
                cnt_q     <= LAT_M1;
            end
            if (state_q == ST_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (state_q == ST_EXEC) begin
                rsp_err_q  <= bad_addr;
                rsp_load_q <= !cap_we && !bad_addr;
            end
            if (state_q == ST_RESP && rsp_ready) begin
                rsp_err_q  <= 1'b0;
                rsp_load_q <= 1'b0;
            end
        end
    end

    dmem_word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (cap_we),
        .addr  (cap_addr[AW+1:2]),
        .wdata (cap_wdata),
        .be    (cap_be),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for data, error, stall and
// reset behaviour, and a LATENCY=0 instance for back-to-back timing.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // LATENCY=2 instance
    logic        rst, req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    state_t      dbg_state;

    // LATENCY=0 instance
    logic        z_rst, z_req_valid, z_req_we, z_rsp_ready;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
    logic [31:0] z_rsp_rdata;
    state_t      z_dbg_state;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy), .dbg_state(dbg_state)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_z (
        .clk(clk), .rst(z_rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_we(z_req_we), .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
        .rsp_err(z_rsp_err), .busy(z_busy), .dbg_state(z_dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (sel) begin
            z_req_valid = v; z_req_we = we; z_req_addr = a; z_req_wdata = d; z_req_be = be;
        end else begin
            req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        end
    endtask

    task automatic set_ready(input bit sel, input logic r);
        if (sel) z_rsp_ready = r;
        else     rsp_ready   = r;
    endtask

    // Called at a negedge with the selected DUT idle; returns at a negedge, idle again.
    // The accept edge counts as edge 1 of the latency.
    task automatic do_req(input bit sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold,
                          input int exp_lat, output logic [31:0] rdata, output logic err);
        int edges;
        chk("req_ready_idle", sel ? z_req_ready : req_ready, 32'd1);
        drive(sel, 1'b1, we, addr, wdata, be);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("busy_after_accept", sel ? z_busy : busy, 32'd1);
        edges = 1;
        while (!(sel ? z_rsp_valid : rsp_valid) && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("rsp_latency", edges, exp_lat);
        rdata = sel ? z_rsp_rdata : rsp_rdata;
        err   = sel ? z_rsp_err : rsp_err;
        for (int i = 0; i < hold; i++) begin
            // An intruding store while the response is stalled must be ignored.
            drive(sel, 1'b1, 1'b1, 32'h10, 32'h0, 4'hF);
            @(posedge clk);
            @(negedge clk);
            chk("hold_rsp_valid", sel ? z_rsp_valid : rsp_valid, 32'd1);
            chk("hold_rsp_rdata", sel ? z_rsp_rdata : rsp_rdata, rdata);
            chk("hold_rsp_err",   sel ? z_rsp_err : rsp_err, err);
            chk("hold_req_ready", sel ? z_req_ready : req_ready, 32'd0);
            chk("hold_busy",      sel ? z_busy : busy, 32'd1);
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_ready(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ready(sel, 1'b0);
        chk("post_hs_rsp_valid", sel ? z_rsp_valid : rsp_valid, 32'd0);
        chk("post_hs_rsp_rdata", sel ? z_rsp_rdata : rsp_rdata, 32'd0);
        chk("post_hs_rsp_err",   sel ? z_rsp_err : rsp_err, 32'd0);
        chk("post_hs_busy",      sel ? z_busy : busy, 32'd0);
    endtask

    task automatic store(input bit sel, input logic [31:0] addr, input logic [31:0] d,
                         input logic [3:0] be, input logic exp_err);
        logic [31:0] r;
        logic e;
        do_req(sel, 1'b1, addr, d, be, 0, sel ? 2 : 4, r, e);
        chk("store_rdata", r, 32'd0);
        chk("store_err", {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic load(input bit sel, input logic [31:0] addr, input int hold,
                        input logic [31:0] exp_d, input logic exp_err);
        logic [31:0] r;
        logic e;
        do_req(sel, 1'b0, addr, 32'h0, 4'h0, hold, sel ? 2 : 4, r, e);
        chk("load_rdata", r, exp_d);
        chk("load_err", {31'd0, e}, {31'd0, exp_err});
    endtask

    initial begin
        rst = 1'b1; z_rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rsp_ready = 1'b0; z_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; z_rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", req_ready, 32'd1);
        chk("reset_rsp_valid", rsp_valid, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err",   rsp_err, 32'd0);
        chk("reset_busy",      busy, 32'd0);
        chk("reset_state",     dbg_state, ST_IDLE);
        chk("reset_z_req_ready", z_req_ready, 32'd1);

        // Full-word store, readback, then a single-byte merge.
        store(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        load (1'b0, 32'h10, 0, 32'hDEADBEEF, 1'b0);
        store(1'b0, 32'h10, 32'h000000AA, 4'b0001, 1'b0);
        load (1'b0, 32'h10, 0, 32'hDEADBEAA, 1'b0);

        // Misaligned and out-of-range requests.
        load (1'b0, 32'h12, 0, 32'h0, 1'b1);
        load (1'b0, 32'h400, 0, 32'h0, 1'b1);
        // 0x400 aliases word 0 if the range check were missing.
        store(1'b0, 32'h0, 32'h11111111, 4'hF, 1'b0);
        store(1'b0, 32'h400, 32'hCAFEF00D, 4'hF, 1'b1);
        load (1'b0, 32'h0, 0, 32'h11111111, 1'b0);
        store(1'b0, 32'h13, 32'h0, 4'hF, 1'b1);
        load (1'b0, 32'h10, 0, 32'hDEADBEAA, 1'b0);

        // Empty byte-enable store is an acked no-op.
        store(1'b0, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0);
        load (1'b0, 32'h10, 0, 32'hDEADBEAA, 1'b0);

        // Response stalled five cycles with a competing request present.
        load (1'b0, 32'h10, 5, 32'hDEADBEAA, 1'b0);
        load (1'b0, 32'h10, 0, 32'hDEADBEAA, 1'b0);

        // Reset during WAIT aborts a store.
        store(1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("abort_in_wait_state", dbg_state, ST_WAIT);
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", rsp_valid, 32'd0);
        chk("abort_busy",      busy, 32'd0);
        chk("abort_rsp_rdata", rsp_rdata, 32'd0);
        chk("abort_rsp_err",   rsp_err, 32'd0);
        chk("abort_state",     dbg_state, ST_IDLE);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", req_ready, 32'd1);
        load (1'b0, 32'h20, 0, 32'h0, 1'b0);

        // Zero-latency instance: back-to-back requests, accepted the cycle after each handshake.
        store(1'b1, 32'h4, 32'h0BADF00D, 4'hF, 1'b0);
        load (1'b1, 32'h4, 0, 32'h0BADF00D, 1'b0);
        load (1'b1, 32'h4, 0, 32'h0BADF00D, 1'b0);
        load (1'b1, 32'h5, 0, 32'h0, 1'b1);
        store(1'b1, 32'h4, 32'h00550000, 4'b0100, 1'b0);
        load (1'b1, 32'h4, 0, 32'h0B55F00D, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
